div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative 32-bit radix-2 restoring divider in the EX stage, downstream of the ALU control
//   decode. Runs when alucontrol is DIV_CONTROL (signed) or DIVU_CONTROL (unsigned).
//   Produces LO = quotient and HI = remainder for the HI/LO register write.
//   Stalls the pipeline while iterating. Abandons the operation on an exception flush.
// PARAMETERS
//   DATA_W   32   operand/result width; iteration count equals DATA_W
// PORTS
//   clk         in   1       single clock; all state updates on posedge
//   rst         in   1       synchronous, active-high reset
//   start       in   1       request; EX asserts while alucontrol is DIV_CONTROL or DIVU_CONTROL
//   signed_div  in   1       1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   opdata1     in   DATA_W  dividend (rs); sampled when start is accepted
//   opdata2     in   DATA_W  divisor (rt); sampled when start is accepted
//   annul       in   1       flush/exception; kills the in-flight or requested op
//   stall_req   out  1       combinational; pipeline holds EX and earlier stages while high
//   valid       out  1       one-cycle pulse; hi/lo are final
//   hi          out  DATA_W  remainder
//   lo          out  DATA_W  quotient
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, valid=0, hi=0, lo=0, counter=0.
//     stall_req then follows its equation.
//   - States: IDLE, CALC, DZERO, DONE. Encodings are localparams in defines.vh.
//   - IDLE:
//       start & ~annul & opdata2!=0 -> CALC; latch |operands|, sign flags, counter=0.
//       start & ~annul & opdata2==0 -> DZERO.
//       start & annul -> remain in IDLE; nothing is latched.
//   - CALC: one quotient bit per cycle. Shift {rem,quo} left 1; trial = rem - divisor.
//       trial non-negative -> rem=trial, quo[0]=1. Otherwise restore rem, quo[0]=0.
//       counter == DATA_W-1 -> DONE.
//   - DZERO: one cycle -> DONE. Result is lo = all ones, hi = dividend unchanged.
//   - DONE: valid=1 for this cycle only. hi/lo are registered here and held until the next
//       accepted start. Next state is always IDLE. start is ignored in DONE, because the
//       stalled pipeline still presents start in the release cycle.
//   - Latency: start accepted at cycle T; CALC T+1..T+32; valid at T+33.
//     Divide-by-zero: valid at T+2.
//   - stall_req = (state==IDLE & start & ~annul) | state==CALC | state==DZERO.
//     It is low in DONE, so the pipeline advances in the same cycle that valid is high.
//   - Signed fix-up, in DONE:
//       quotient is negated if the operand signs differ;
//       remainder takes the sign of the dividend.
//     0x80000000 / -1 (signed) gives lo=0x80000000, hi=0; no trap is raised.
//   - annul while in CALC or DZERO -> IDLE at the next edge. valid stays 0; hi/lo keep
//     their previous values.
//   - annul while in DONE: the result still pulses valid. The consumer gates the HI/LO write
//     with its own flush.
//   - rst overrides every state, including mid-CALC; no partial result becomes visible.
//   - Unsigned magnitude path is DATA_W+1 bits wide, so the trial subtract never overflows.
// STRUCTURE
//   - defines.vh:
//       DIV_CONTROL and DIVU_CONTROL, already shared with the ALU control decode;
//       add DIV_IDLE/DIV_CALC/DIV_DZERO/DIV_DONE state codes.
//   - One combinational sub-module, div_step: one restoring-subtract iteration,
//     (rem,quo,divisor) -> (rem',quo').
//   - FSM, counter, operand latch and sign fix-up live in div_unit.
// TESTING
//   1. Unsigned: DIVU 100/7.
//      -> valid exactly 33 cycles after start; lo=14, hi=2; stall_req high for 33 cycles.
//   2. Signed mixed signs: DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//      Also 7/-2 -> lo=-3, hi=1.
//   3. Signed overflow: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//      Also DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
//   4. Divide by zero: DIV 5/0 -> valid at T+2; lo=0xFFFFFFFF, hi=5.
//   5. annul at cycle T+10 of an op -> IDLE next cycle; no valid pulse; hi/lo unchanged.
//      A fresh start two cycles later completes correctly.
//   6. Handshake: start held high through DONE -> exactly one valid and no restart.
//      Then rst asserted mid-CALC -> valid=0, hi=lo=0 on the next cycle.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared decode codes and divider state encodings.
// Imported by the EX-stage divider and its datapath step.
package div_unit_pkg;

    localparam logic [4:0] DIV_CONTROL  = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL = 5'b11011;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_CALC  = 2'd1,
        DIV_DZERO = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes.
// Shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_nxt,
    output logic [DATA_W-1:0] quo_nxt
);

    logic [DATA_W+1:0] rem_sh;
    logic [DATA_W+1:0] trial;
    logic              neg;

    assign rem_sh = {rem, quo[DATA_W-1]};
    assign trial  = rem_sh - {2'b00, divisor};
    assign neg    = trial[DATA_W+1];

    always_comb begin
        rem_nxt = neg ? rem_sh[DATA_W:0] : trial[DATA_W:0];
        quo_nxt = {quo[DATA_W-2:0], ~neg};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Stalls the pipeline while iterating; result pulses valid in DONE.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] opdata1,
    input  logic [DATA_W-1:0] opdata2,
    input  logic              annul,
    output logic              stall_req,
    output logic              valid,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    div_state_t        state;
    div_state_t        state_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W:0]   rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic              req;
    logic              dzero;
    logic              sgn1;
    logic              sgn2;
    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;

    assign req   = start & ~annul;
    assign dzero = (opdata2 == '0);
    assign sgn1  = signed_div & opdata1[DATA_W-1];
    assign sgn2  = signed_div & opdata2[DATA_W-1];
    assign abs1  = sgn1 ? -opdata1 : opdata1;
    assign abs2  = sgn2 ? -opdata2 : opdata2;

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE:
                if (req) state_nxt = dzero ? DIV_DZERO : DIV_CALC;
            DIV_CALC:
                if (annul)            state_nxt = DIV_IDLE;
                else if (cnt == LAST) state_nxt = DIV_DONE;
            DIV_DZERO:
                state_nxt = annul ? DIV_IDLE : DIV_DONE;
            DIV_DONE:
                state_nxt = DIV_IDLE;
            default:
                state_nxt = DIV_IDLE;
        endcase
    end

    assign stall_req = (state == DIV_IDLE & req)
                     | (state == DIV_CALC)
                     | (state == DIV_DZERO);
    assign valid     = (state == DIV_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                DIV_IDLE: begin
                    // quo carries the raw dividend on the divide-by-zero path
                    if (req) begin
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= dzero ? opdata1 : abs1;
                        dvs   <= abs2;
                        neg_q <= sgn1 ^ sgn2;
                        neg_r <= sgn1;
                    end
                end
                DIV_CALC: begin
                    if (!annul) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            lo <= neg_q ? -quo_nxt : quo_nxt;
                            hi <= neg_r ? -rem_nxt[DATA_W-1:0]
                                        : rem_nxt[DATA_W-1:0];
                        end
                    end
                end
                DIV_DZERO: begin
                    if (!annul) begin
                        lo <= '1;
                        hi <= quo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Each task drives one scenario and checks latency, stall and results.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stall_req;
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_bad;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .stall_req  (stall_req),
        .valid      (valid),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op at the next negedge and follows it to valid.
    task automatic do_div(input string name, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi,
                          input int exp_lat, input bit hold);
        int k;
        int stalls;
        int found;
        k = 0;
        stalls = 0;
        found = -1;
        @(negedge clk);
        start = 1'b1;
        signed_div = sgn;
        opdata1 = a;
        opdata2 = b;
        #1;
        while (found < 0 && k < 60) begin
            if (valid) begin
                found = k;
            end else begin
                if (stall_req) stalls++;
                @(negedge clk);
                #1;
                k++;
            end
        end
        n_cmp++;
        if (found !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, found, exp_lat);
        end
        n_cmp++;
        if (stalls !== exp_lat) begin
            n_bad++;
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, exp_lat);
        end
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s stall in done: got %b want 0", name, stall_req);
        end
        n_cmp++;
        if (lo !== exp_lo) begin
            n_bad++;
            $display("FAIL %s lo: got %h want %h", name, lo, exp_lo);
        end
        n_cmp++;
        if (hi !== exp_hi) begin
            n_bad++;
            $display("FAIL %s hi: got %h want %h", name, hi, exp_hi);
        end
        if (!hold) start = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s valid pulse width: got %b want 0", name, valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        opdata1 = '0;
        opdata2 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset valid: got %b want 0", valid);
        end
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset stall_req: got %b want 0", stall_req);
        end
        n_cmp++;
        if (hi !== 32'h0) begin
            n_bad++;
            $display("FAIL reset hi: got %h want 0", hi);
        end
        n_cmp++;
        if (lo !== 32'h0) begin
            n_bad++;
            $display("FAIL reset lo: got %h want 0", lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        do_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE,
               32'd1, 32'd1, 33, 1'b0);
    endtask

    task automatic test_signed();
        do_div("div_m7_2", 1'b1, -32'sd7, 32'd2,
               32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
        do_div("div_7_m2", 1'b1, 32'd7, -32'sd2,
               32'hFFFFFFFD, 32'd1, 33, 1'b0);
        do_div("div_m7_m2", 1'b1, -32'sd7, -32'sd2,
               32'd3, 32'hFFFFFFFF, 33, 1'b0);
    endtask

    task automatic test_overflow();
        do_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 32'h0, 33, 1'b0);
        do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
               32'hFFFFFFFF, 32'h0, 33, 1'b0);
    endtask

    task automatic test_dzero();
        do_div("div_5_0", 1'b1, 32'd5, 32'd0,
               32'hFFFFFFFF, 32'd5, 2, 1'b0);
    endtask

    task automatic test_annul();
        @(negedge clk);
        start = 1'b1;
        signed_div = 1'b0;
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        repeat (10) @(negedge clk);
        start = 1'b0;
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_bad++;
            $display("FAIL annul idle stall_req: got %b want 0", stall_req);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL annul valid: got %b want 0", valid);
        end
        n_cmp++;
        if ({hi, lo} !== {32'd5, 32'hFFFFFFFF}) begin
            n_bad++;
            $display("FAIL annul hi_lo kept: got %h want %h",
                     {hi, lo}, {32'd5, 32'hFFFFFFFF});
        end
        do_div("after_annul", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 33, 1'b0);
    endtask

    task automatic test_handshake();
        int pulses;
        int stalls;
        pulses = 0;
        stalls = 0;
        do_div("hold_start", 1'b0, 32'd1234, 32'd10, 32'd123, 32'd4, 33, 1'b1);
        repeat (40) begin
            @(negedge clk);
            if (valid) pulses++;
            if (stall_req) stalls++;
        end
        n_cmp++;
        if (pulses !== 0 || stalls !== 0) begin
            n_bad++;
            $display("FAIL no restart: got %0d valid %0d stall want 0 0",
                     pulses, stalls);
        end
        @(negedge clk);
        start = 1'b1;
        opdata1 = 32'd50;
        opdata2 = 32'd5;
        repeat (10) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({valid, stall_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst mid calc valid_stall: got %b want 00",
                     {valid, stall_req});
        end
        n_cmp++;
        if ({hi, lo} !== 64'h0) begin
            n_bad++;
            $display("FAIL rst mid calc hi_lo: got %h want 0", {hi, lo});
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL rst no late valid: got %0d want 0", pulses);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_dzero();
        test_annul();
        test_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
